// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: data width, base opcodes and the
// fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic: sequential or branch target, plus alignment check of
// the selected target. Purely combinational, wraps modulo 2^32.
module pc_next
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic            branch_i,
    input  logic            zero_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    logic take_branch;

    assign take_branch = branch_i & zero_i;
    assign pc_plus4_o  = pc_i + 32'd4;
    assign target_o    = take_branch ? (pc_i + imm_ext_i) : pc_plus4_o;
    assign misalign_o  = |target_o[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches over a req/ready handshake
// and presents one instruction at a time to the decoder.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            Branch,
    input  logic            zero,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            stall,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] Instr,
    output logic [6:0]      Op,
    output logic            instr_valid,
    output logic            misalign
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] target;
    logic            target_misalign;

    pc_next u_pc_next (
        .pc_i       (pc_q),
        .imm_ext_i  (ImmExt),
        .branch_i   (Branch),
        .zero_i     (zero),
        .pc_plus4_o (PCPlus4),
        .target_o   (target),
        .misalign_o (target_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A stall freezes everything, even a resolved taken branch.
                if (!stall) begin
                    if (target_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = target;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_EXEC);
    assign Op          = instr_valid ? instr_q[6:0] : 7'b0000000;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed fetch sequences push
// expected PCs, a negedge monitor checks each executed instruction.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, RESET_PC = 0
    logic        rst = 1'b1;
    logic        imem_ready = 1'b1;
    logic        branch = 1'b0, zero = 1'b0, stall = 1'b0;
    logic [31:0] imm_ext = 32'd0;
    logic        imem_req, instr_valid, misalign;
    logic [31:0] imem_addr, imem_rdata, PC, PCPlus4, Instr;
    logic [6:0]  Op;

    // Second DUT, RESET_PC at the top of the address space
    logic        rst1 = 1'b1;
    logic        imem_ready1 = 1'b1;
    logic        branch1 = 1'b0, zero1 = 1'b0, stall1 = 1'b0;
    logic [31:0] imm_ext1 = 32'd0;
    logic        imem_req1, instr_valid1, misalign1;
    logic [31:0] imem_addr1, imem_rdata1, PC1, PCPlus4_1, Instr1;
    logic [6:0]  Op1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[27:0], 4'h3};
    endfunction

    assign imem_rdata  = imem_ready  ? mem_word(imem_addr)  : 32'hDEAD_BEEF;
    assign imem_rdata1 = imem_ready1 ? mem_word(imem_addr1) : 32'hDEAD_BEEF;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Branch(branch),
        .zero(zero), .ImmExt(imm_ext), .stall(stall), .PC(PC),
        .PCPlus4(PCPlus4), .Instr(Instr), .Op(Op),
        .instr_valid(instr_valid), .misalign(misalign)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst1), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ready(imem_ready1), .imem_rdata(imem_rdata1), .Branch(branch1),
        .zero(zero1), .ImmExt(imm_ext1), .stall(stall1), .PC(PC1),
        .PCPlus4(PCPlus4_1), .Instr(Instr1), .Op(Op1),
        .instr_valid(instr_valid1), .misalign(misalign1)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Scoreboard: expected PC of every instruction the DUT should execute
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;

    initial begin
        logic        prev_valid;
        logic [31:0] e, w;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (instr_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL exec_unexpected: pc %h executed, none expected", PC);
                    end else begin
                        e = exp_q.pop_front();
                        w = mem_word(e);
                        chk("exec_pc", PC, e);
                        chk("exec_instr", Instr, w);
                        chk("exec_op", {25'd0, Op}, {25'd0, w[6:0]});
                        $display("exec pc=%h instr=%h op=%b", PC, Instr, Op);
                    end
                end
                if (!instr_valid) chk("op_idle", {25'd0, Op}, 32'd0);
                prev_valid = instr_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From EXEC (or BOOT): one fetch at a with immediate ready, then EXEC.
    task automatic go(input logic [31:0] a);
        exp_q.push_back(a);
        tick();
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, a);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst  = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_op", {25'd0, Op}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_pcplus4", PCPlus4, 32'h4);
        chk("rst_pc_wrap", PC1, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("rst_hold_req", {31'd0, imem_req}, 32'd0);

        // Release with ready tied high: 0x0, 0x4, 0x8 at one per 2 cycles
        rst = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pulse_valid", {31'd0, instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                chk("seq_req", {31'd0, imem_req}, 32'd1);
                chk("seq_addr", imem_addr, 32'(i * 2));
            end
        end

        // Memory wait: ready low for 3 cycles on fetch at 0xC
        imem_ready = 1'b0;
        exp_q.push_back(32'hC);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'hC);
            chk("wait_pc", PC, 32'hC);
            if (k == 3) imem_ready = 1'b1;
            tick();
        end
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);

        // Taken branch backwards from 0x10, then not-taken from 0x10
        go(32'h10);
        branch = 1'b1; zero = 1'b1; imm_ext = 32'hFFFF_FFF8;
        go(32'h8);
        branch = 1'b0; zero = 1'b0;
        go(32'hC);
        go(32'h10);
        branch = 1'b1; zero = 1'b0;
        go(32'h14);
        branch = 1'b0;
        go(32'h18);
        go(32'h1C);
        go(32'h20);

        // Stall for 5 cycles at 0x20 while a taken branch is presented
        stall = 1'b1; branch = 1'b1; zero = 1'b1; imm_ext = 32'h100;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", PC, 32'h20);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        stall = 1'b0; branch = 1'b0; zero = 1'b0;
        go(32'h24);
        for (int a = 32'h28; a <= 32'h40; a += 4) go(32'(a));

        // Misaligned taken branch from 0x40 halts the unit
        branch = 1'b1; zero = 1'b1; imm_ext = 32'h6;
        tick();
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_pc", PC, 32'h40);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_misalign", {31'd0, misalign}, 32'd1);
        end
        branch = 1'b0; zero = 1'b0; imm_ext = 32'd0;
        #2;
        rst = 1'b0;
        #1;
        chk("clr_misalign", {31'd0, misalign}, 32'd0);
        chk("clr_pc", PC, 32'h0);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL sb_drain: %0d expected instructions never executed, required 0", exp_q.size());

        // Wrap-around DUT: 0xFFFFFFFC then 0x0, then reset mid-fetch
        tick();
        rst1 = 1'b1;
        tick();
        chk("wrap_req", {31'd0, imem_req1}, 32'd1);
        chk("wrap_addr0", imem_addr1, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4_1, 32'h0);
        tick();
        chk("wrap_valid", {31'd0, instr_valid1}, 32'd1);
        chk("wrap_instr", Instr1, 32'hFFFF_FFC3);
        $display("exec pc=%h instr=%h op=%b", PC1, Instr1, Op1);
        tick();
        chk("wrap_addr1", imem_addr1, 32'h0);
        chk("wrap_misalign", {31'd0, misalign1}, 32'd0);
        imem_ready1 = 1'b0;
        tick();
        chk("midfetch_req", {31'd0, imem_req1}, 32'd1);
        #3;
        rst1 = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, imem_req1}, 32'd0);
        chk("async_pc", PC1, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
